// File: rtl/procyon_lsu_arbiter.sv
// procyon_lsu_arbiter: LSU stage 0 op select (sq retire > replay > exec) into a registered op bundle.
// Define PCYN_LSU_STARVE_GUARD_EN to add the execute starvation guard.
module procyon_lsu_arbiter #(
    parameter int PCYN_LSU_FUNC_WIDTH = 4,
    parameter int OPTN_DATA_WIDTH     = 32,
    parameter int OPTN_ADDR_WIDTH     = 32,
    parameter int OPTN_LQ_DEPTH       = 8,
    parameter int OPTN_SQ_DEPTH       = 8,
    parameter int OPTN_ROB_IDX_WIDTH  = 5,
    parameter int OPTN_STARVE_LIMIT   = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           i_flush,
    input  logic                           i_stall,
    input  logic                           i_exec_valid,
    input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_exec_lsu_func,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_exec_tag,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_exec_addr,
    output logic                           o_exec_stall,
    input  logic                           i_replay_valid,
    input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_replay_lsu_func,
    input  logic [OPTN_LQ_DEPTH-1:0]       i_replay_lq_select,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_replay_tag,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_replay_addr,
    output logic                           o_replay_ack,
    input  logic                           i_sq_retire_valid,
    input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_sq_retire_lsu_func,
    input  logic [OPTN_SQ_DEPTH-1:0]       i_sq_retire_select,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_sq_retire_tag,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_sq_retire_addr,
    input  logic [OPTN_DATA_WIDTH-1:0]     i_sq_retire_data,
    output logic                           o_sq_retire_ack,
    output logic                           o_valid,
    output logic [PCYN_LSU_FUNC_WIDTH-1:0] o_lsu_func,
    output logic [OPTN_LQ_DEPTH-1:0]       o_lq_select,
    output logic [OPTN_SQ_DEPTH-1:0]       o_sq_select,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]  o_tag,
    output logic [OPTN_ADDR_WIDTH-1:0]     o_addr,
    output logic [OPTN_DATA_WIDTH-1:0]     o_retire_data,
    output logic                           o_retire,
    output logic                           o_replay
);

    logic en;
    logic starve_force;
    logic sq_grant, replay_grant, exec_grant;

    logic                           valid_q, valid_d;
    logic [PCYN_LSU_FUNC_WIDTH-1:0] lsu_func_q, lsu_func_d;
    logic [OPTN_LQ_DEPTH-1:0]       lq_select_q, lq_select_d;
    logic [OPTN_SQ_DEPTH-1:0]       sq_select_q, sq_select_d;
    logic [OPTN_ROB_IDX_WIDTH-1:0]  tag_q, tag_d;
    logic [OPTN_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [OPTN_DATA_WIDTH-1:0]     retire_data_q, retire_data_d;
    logic                           retire_q, retire_d;
    logic                           replay_q, replay_d;

    assign en = n_rst & ~i_stall;

`ifdef PCYN_LSU_STARVE_GUARD_EN
    localparam int CW = $clog2(OPTN_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(OPTN_STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = i_exec_valid & ~i_flush & (starve_cnt_q == LIMIT);

    // Flush cycles neither count as starvation nor reset the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (en) begin
            if (!i_exec_valid || exec_grant) starve_cnt_d = '0;
            else if (!i_flush && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) starve_cnt_q <= '0;
        else starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        sq_grant     = en & i_sq_retire_valid & ~starve_force;
        replay_grant = en & ~i_flush & i_replay_valid & ~i_sq_retire_valid & ~starve_force;
        exec_grant   = en & ~i_flush & i_exec_valid & (starve_force | (~i_sq_retire_valid & ~i_replay_valid));
    end

    assign o_sq_retire_ack = sq_grant;
    assign o_replay_ack    = replay_grant;
    assign o_exec_stall    = i_exec_valid & ~exec_grant;

    // A stalled flush keeps only a held committed store alive.
    always_comb begin
        valid_d       = i_stall ? valid_q & (~i_flush | retire_q) : sq_grant | replay_grant | exec_grant;
        lsu_func_d    = i_stall ? lsu_func_q :
                        sq_grant ? i_sq_retire_lsu_func :
                        replay_grant ? i_replay_lsu_func :
                        exec_grant ? i_exec_lsu_func : '0;
        tag_d         = i_stall ? tag_q :
                        sq_grant ? i_sq_retire_tag :
                        replay_grant ? i_replay_tag :
                        exec_grant ? i_exec_tag : '0;
        addr_d        = i_stall ? addr_q :
                        sq_grant ? i_sq_retire_addr :
                        replay_grant ? i_replay_addr :
                        exec_grant ? i_exec_addr : '0;
        lq_select_d   = i_stall ? lq_select_q : (replay_grant ? i_replay_lq_select : '0);
        sq_select_d   = i_stall ? sq_select_q : (sq_grant ? i_sq_retire_select : '0);
        retire_data_d = i_stall ? retire_data_q : (sq_grant ? i_sq_retire_data : '0);
        retire_d      = i_stall ? retire_q : sq_grant;
        replay_d      = i_stall ? replay_q : replay_grant;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_q       <= 1'b0;
            lsu_func_q    <= '0;
            lq_select_q   <= '0;
            sq_select_q   <= '0;
            tag_q         <= '0;
            addr_q        <= '0;
            retire_data_q <= '0;
            retire_q      <= 1'b0;
            replay_q      <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            lsu_func_q    <= lsu_func_d;
            lq_select_q   <= lq_select_d;
            sq_select_q   <= sq_select_d;
            tag_q         <= tag_d;
            addr_q        <= addr_d;
            retire_data_q <= retire_data_d;
            retire_q      <= retire_d;
            replay_q      <= replay_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_lsu_func    = lsu_func_q;
    assign o_lq_select   = lq_select_q;
    assign o_sq_select   = sq_select_q;
    assign o_tag         = tag_q;
    assign o_addr        = addr_q;
    assign o_retire_data = retire_data_q;
    assign o_retire      = retire_q;
    assign o_replay      = replay_q;

endmodule

// File: tb/tb_procyon_lsu_arbiter.sv
// tb_procyon_lsu_arbiter: directed vector table plus stall, flush and starvation sequences.
module tb_procyon_lsu_arbiter;

    localparam logic [3:0]  EX_FUNC = 4'h3;
    localparam logic [4:0]  EX_TAG  = 5'd7;
    localparam logic [31:0] EX_ADDR = 32'h1000_0040;
    localparam logic [3:0]  RP_FUNC = 4'h5;
    localparam logic [7:0]  RP_LQ   = 8'h10;
    localparam logic [4:0]  RP_TAG  = 5'd12;
    localparam logic [31:0] RP_ADDR = 32'h2000_0080;
    localparam logic [3:0]  SQ_FUNC = 4'h9;
    localparam logic [7:0]  SQ_SEL  = 8'h04;
    localparam logic [4:0]  SQ_TAG  = 5'd20;
    localparam logic [31:0] SQ_ADDR = 32'h3000_00C0;
    localparam logic [31:0] SQ_DATA = 32'hDEADBEEF;

    localparam int K_NONE = 0, K_SQ = 1, K_RP = 2, K_EX = 3;

    logic clk = 1'b0;
    logic n_rst, i_flush, i_stall;
    logic i_exec_valid, i_replay_valid, i_sq_retire_valid;
    logic o_exec_stall, o_replay_ack, o_sq_retire_ack;
    logic o_valid, o_retire, o_replay;
    logic [3:0]  o_lsu_func;
    logic [7:0]  o_lq_select, o_sq_select;
    logic [4:0]  o_tag;
    logic [31:0] o_addr, o_retire_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    procyon_lsu_arbiter dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_stall(i_stall),
        .i_exec_valid(i_exec_valid), .i_exec_lsu_func(EX_FUNC), .i_exec_tag(EX_TAG),
        .i_exec_addr(EX_ADDR), .o_exec_stall(o_exec_stall),
        .i_replay_valid(i_replay_valid), .i_replay_lsu_func(RP_FUNC),
        .i_replay_lq_select(RP_LQ), .i_replay_tag(RP_TAG), .i_replay_addr(RP_ADDR),
        .o_replay_ack(o_replay_ack),
        .i_sq_retire_valid(i_sq_retire_valid), .i_sq_retire_lsu_func(SQ_FUNC),
        .i_sq_retire_select(SQ_SEL), .i_sq_retire_tag(SQ_TAG), .i_sq_retire_addr(SQ_ADDR),
        .i_sq_retire_data(SQ_DATA), .o_sq_retire_ack(o_sq_retire_ack),
        .o_valid(o_valid), .o_lsu_func(o_lsu_func), .o_lq_select(o_lq_select),
        .o_sq_select(o_sq_select), .o_tag(o_tag), .o_addr(o_addr),
        .o_retire_data(o_retire_data), .o_retire(o_retire), .o_replay(o_replay)
    );

    typedef struct {
        logic fl, st, ev, rv, sv;
        logic x_sq_ack, x_rp_ack, x_ex_stall;
        int   kind;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input logic ev, input logic rv, input logic sv);
        i_flush = fl; i_stall = st; i_exec_valid = ev; i_replay_valid = rv; i_sq_retire_valid = sv;
    endtask

    task automatic chk_acks(input string nm, input logic sq, input logic rp, input logic es);
        chk({nm, ".sq_ack"}, 64'(o_sq_retire_ack), 64'(sq));
        chk({nm, ".replay_ack"}, 64'(o_replay_ack), 64'(rp));
        chk({nm, ".exec_stall"}, 64'(o_exec_stall), 64'(es));
    endtask

    // Expected registered bundle for a given winning requester.
    task automatic chk_out(input string nm, input int kind);
        chk({nm, ".valid"}, 64'(o_valid), 64'(kind != K_NONE));
        chk({nm, ".func"}, 64'(o_lsu_func), 64'(kind == K_SQ ? SQ_FUNC : kind == K_RP ? RP_FUNC : kind == K_EX ? EX_FUNC : 4'h0));
        chk({nm, ".tag"}, 64'(o_tag), 64'(kind == K_SQ ? SQ_TAG : kind == K_RP ? RP_TAG : kind == K_EX ? EX_TAG : 5'd0));
        chk({nm, ".addr"}, 64'(o_addr), 64'(kind == K_SQ ? SQ_ADDR : kind == K_RP ? RP_ADDR : kind == K_EX ? EX_ADDR : 32'h0));
        chk({nm, ".lq_select"}, 64'(o_lq_select), 64'(kind == K_RP ? RP_LQ : 8'h0));
        chk({nm, ".sq_select"}, 64'(o_sq_select), 64'(kind == K_SQ ? SQ_SEL : 8'h0));
        chk({nm, ".retire_data"}, 64'(o_retire_data), 64'(kind == K_SQ ? SQ_DATA : 32'h0));
        chk({nm, ".retire"}, 64'(o_retire), 64'(kind == K_SQ));
        chk({nm, ".replay"}, 64'(o_replay), 64'(kind == K_RP));
    endtask

    task automatic rst_dut();
        @(negedge clk);
        n_rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        vecs[0] = '{0, 0, 1, 1, 1, 1, 0, 1, K_SQ};
        vecs[1] = '{0, 0, 1, 1, 0, 0, 1, 1, K_RP};
        vecs[2] = '{0, 0, 1, 0, 0, 0, 0, 0, K_EX};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, K_NONE};
        vecs[4] = '{1, 0, 1, 1, 1, 1, 0, 1, K_SQ};
        vecs[5] = '{1, 0, 1, 0, 0, 0, 0, 1, K_NONE};
        vecs[6] = '{1, 0, 1, 1, 0, 0, 0, 1, K_NONE};
        vecs[7] = '{0, 0, 0, 0, 1, 1, 0, 0, K_SQ};
        vecs[8] = '{0, 1, 1, 1, 1, 0, 0, 1, K_NONE};
        vecs[9] = '{0, 0, 0, 1, 0, 0, 1, 0, K_RP};

        n_rst = 1'b0;
        drive(0, 0, 1, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_acks("reset", 0, 0, 1);
        chk_out("reset", K_NONE);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rst_dut();
            drive(vecs[i].fl, vecs[i].st, vecs[i].ev, vecs[i].rv, vecs[i].sv);
            #1;
            chk_acks($sformatf("vec%0d", i), vecs[i].x_sq_ack, vecs[i].x_rp_ack, vecs[i].x_ex_stall);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].kind);
        end

        // Stall holds a granted store for three cycles, then replay wins on release.
        rst_dut();
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_acks($sformatf("stall%0d", i), 0, 0, 1);
            @(posedge clk);
            #1;
            chk_out($sformatf("stall%0d", i), K_SQ);
            @(negedge clk);
        end
        drive(0, 0, 1, 1, 0);
        #1;
        chk_acks("release", 0, 1, 1);
        @(posedge clk);
        #1;
        chk_out("release", K_RP);

        // Flush during stall drops a held replay op.
        @(negedge clk);
        drive(1, 1, 1, 1, 0);
        #1;
        chk_acks("flst_rp", 0, 0, 1);
        @(posedge clk);
        #1;
        chk("flst_rp.valid", 64'(o_valid), 64'(0));

        // Flush during stall keeps a held committed store.
        rst_dut();
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1, 1, 0, 1);
        #1;
        chk_acks("flst_sq", 0, 0, 1);
        @(posedge clk);
        #1;
        chk("flst_sq.valid", 64'(o_valid), 64'(1));
        chk("flst_sq.retire", 64'(o_retire), 64'(1));

        // Continuous replay competing with execute.
        rst_dut();
        drive(0, 0, 1, 1, 0);
`ifdef PCYN_LSU_STARVE_GUARD_EN
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk_acks($sformatf("starve%0d", i), 0, i != 5, i != 5);
            @(posedge clk);
            #1;
            chk_out($sformatf("starve%0d", i), i == 5 ? K_EX : K_RP);
            @(negedge clk);
        end
`else
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk_acks($sformatf("starve%0d", i), 0, 1, 1);
            @(posedge clk);
            #1;
            chk_out($sformatf("starve%0d", i), K_RP);
            @(negedge clk);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
